cj: RTL and testbench
=====================

# cj

Commit-stream co-simulation checker between the core pipeline and the testbench end-of-test logic. Buffers golden-model commit records in a FIFO and compares each core commit against the FIFO head. Drives the 64-bit `tohost` status word the bench polls: bit 0 set means the test is over, and the upper bits carry a pass or fail code.

## Interface
- `XLEN`, 64: datapath width for PC, write data and store data.
- `DEPTH`, 8: reference FIFO depth; must be a power of two, at least 2.
- `TOHOST_ADDR`, 64'h8000_1000: store address that writes `tohost`.
- `clock` in 1: single clock; all state is updated on its rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `dut_valid` in 1: core commits one instruction this cycle.
- `dut_pc` in XLEN, `dut_inst` in 32, `dut_wen` in 1, `dut_rd` in 5, `dut_wdata` in XLEN: the core commit record.
- `ref_valid` in 1: golden-model record offered.
- `ref_ready` out 1: FIFO can accept a golden-model record.
- `ref_pc`, `ref_inst`, `ref_wen`, `ref_rd`, `ref_wdata`: golden-model record, same widths as the core record.
- `st_valid` in 1, `st_addr` in XLEN, `st_data` in XLEN: committed store observed from the core.
- `set_valid` in 1, `set_value` in 64: external override of `tohost`; the bench uses value 5 for timeout.
- `tohost` out 64: status word.
- `mismatch` out 1: sticky flag, set once a compare error has been recorded.
- `commit_count` out 64: number of commits that compared equal.

## Operation
- FIFO: push when `ref_valid & ref_ready`; `ref_ready = !full`. There is no full bypass, so a push and a pop in the same cycle while full is not possible.
- Compare: on `dut_valid` while `done = tohost[0]` is 0, pop the FIFO head and compare it with the core record. Check in priority order; the first failure wins:
  - FIFO empty: code 0x27.
  - `pc` differs: 0x21.
  - `inst` differs: 0x23.
  - `wen` differs, or `wen=1` and `rd` differs: 0x29.
  - `wen=1`, `rd!=0` and `wdata` differs: 0x25.
- Compare error: `tohost <= code`, `mismatch <= 1`.
- Successful compare: `commit_count` increments by 1.
- Store: `st_valid & st_addr==TOHOST_ADDR & st_data!=0 & !done` gives `tohost <= st_data`. A store of 1 signals pass. A store of 0 is ignored.
- Override: `set_valid` gives `tohost <= set_value`, regardless of `done`.
- Same-cycle priority: set > compare error > store. A matching commit and a tohost store in the same cycle both take effect: the count increments and `tohost` takes the store value.
- Once `done`:
  - Compares, FIFO pops and count updates freeze.
  - FIFO pushes continue until the FIFO is full.
  - `mismatch` holds its value.
- `commit_count` wraps modulo 2^64.

## Timing
- Reset values:
  - `tohost=0`, `mismatch=0`, `commit_count=0`.
  - FIFO empty; `ref_ready=1`.
- `tohost`, `mismatch` and `commit_count` are registered and change the cycle after the triggering event, i.e. 1-cycle latency.
- A record pushed at edge N can be compared by a commit sampled at edge N+1 or later.
- `ref_ready` is combinational from the FIFO occupancy only.
- Reset asserted mid-test clears everything immediately, with no clock needed. Outputs return to their reset values asynchronously.
- The FIFO pointers wrap at DEPTH. Full and empty are distinguished by an extra pointer bit.

## Test plan
- Push 3 matching records, commit 3 matching, then store 1 to 0x8000_1000 -> `commit_count=3`, `tohost=1` one cycle after the store, `mismatch=0`.
- Record with pc=0x80000004 and commit with pc=0x80000008 -> `tohost=0x21`, `mismatch=1`. A further store of 1 leaves `tohost=0x21`.
- Commit with `wen=1`, `rd=5`, ref wdata=0x10, dut wdata=0x11 -> `tohost=0x25`. Same mismatch with `rd=0` -> no error, count increments.
- `dut_valid` with the FIFO empty -> `tohost=0x27` next cycle.
- Fill DEPTH=8 records -> `ref_ready=0`. One commit -> `ref_ready=1` next cycle.
- `set_valid` with value 5 in the same cycle as a mismatching commit -> `tohost=5`. Assert reset low -> `tohost=0`, `commit_count=0`, `ref_ready=1` with no clock edge.

Source files
------------

// File: rtl/cj.sv
// Commit-stream co-simulation checker.
// Buffers golden-model commit records and compares each core commit against
// the oldest buffered record. Maintains the tohost status word, a sticky
// mismatch flag and a count of commits that compared equal.
module cj #(
  parameter int unsigned     XLEN        = 64,
  parameter int unsigned     DEPTH       = 8,
  parameter logic [XLEN-1:0] TOHOST_ADDR = 'h8000_1000
) (
  input  logic            clock,
  input  logic            reset,
  // core commit record
  input  logic            dut_valid,
  input  logic [XLEN-1:0] dut_pc,
  input  logic [31:0]     dut_inst,
  input  logic            dut_wen,
  input  logic [4:0]      dut_rd,
  input  logic [XLEN-1:0] dut_wdata,
  // golden-model record
  input  logic            ref_valid,
  output logic            ref_ready,
  input  logic [XLEN-1:0] ref_pc,
  input  logic [31:0]     ref_inst,
  input  logic            ref_wen,
  input  logic [4:0]      ref_rd,
  input  logic [XLEN-1:0] ref_wdata,
  // committed store
  input  logic            st_valid,
  input  logic [XLEN-1:0] st_addr,
  input  logic [XLEN-1:0] st_data,
  // external override
  input  logic            set_valid,
  input  logic [63:0]     set_value,
  // status
  output logic [63:0]     tohost,
  output logic            mismatch,
  output logic [63:0]     commit_count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // record layout: {pc, inst, wen, rd, wdata}
  localparam int unsigned RW = 2 * XLEN + 38;

  localparam logic [63:0] CodePc    = 64'h21;
  localparam logic [63:0] CodeInst  = 64'h23;
  localparam logic [63:0] CodeWdata = 64'h25;
  localparam logic [63:0] CodeEmpty = 64'h27;
  localparam logic [63:0] CodeRd    = 64'h29;

  logic [RW-1:0] mem_q [DEPTH];
  logic [RW-1:0] mem_d [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [63:0]   tohost_q, tohost_d;
  logic          mismatch_q, mismatch_d;
  logic [63:0]   count_q, count_d;

  logic          full, empty, done, push, cmp, pop, err;
  logic [63:0]   err_code;
  logic [RW-1:0] head, ref_rec;
  logic [XLEN-1:0] h_pc, h_wdata;
  logic [31:0]   h_inst;
  logic          h_wen;
  logic [4:0]    h_rd;
  logic          st_hit;

  assign ref_rec = {ref_pc, ref_inst, ref_wen, ref_rd, ref_wdata};
  assign head    = mem_q[rd_ptr_q[AW-1:0]];
  assign {h_pc, h_inst, h_wen, h_rd, h_wdata} = head;

  // Occupancy flags: the extra pointer bit separates full from empty.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  end

  assign ref_ready = !full;
  assign done      = tohost_q[0];
  assign push      = ref_valid && !full;
  assign cmp       = dut_valid && !done;
  assign pop       = cmp && !empty;
  assign st_hit    = st_valid && (st_addr == TOHOST_ADDR) && (st_data != '0) && !done;

  // Prioritised compare of the core record against the FIFO head.
  always_comb begin
    err_code = '0;
    if (empty) begin
      err_code = CodeEmpty;
    end else if (dut_pc != h_pc) begin
      err_code = CodePc;
    end else if (dut_inst != h_inst) begin
      err_code = CodeInst;
    end else if ((dut_wen != h_wen) || (dut_wen && (dut_rd != h_rd))) begin
      err_code = CodeRd;
    end else if (dut_wen && (dut_rd != 5'd0) && (dut_wdata != h_wdata)) begin
      err_code = CodeWdata;
    end
    err = cmp && (err_code != '0);
  end

  // FIFO next state: write at the tail, advance the head on a compare.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = ref_rec;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Status next state: override beats compare error beats tohost store.
  always_comb begin
    tohost_d   = tohost_q;
    mismatch_d = mismatch_q;
    count_d    = count_q;
    if (set_valid) begin
      tohost_d = set_value;
    end else if (err) begin
      tohost_d = err_code;
    end else if (st_hit) begin
      tohost_d = 64'(st_data);
    end
    if (err) begin
      mismatch_d = 1'b1;
    end
    if (cmp && !err) begin
      count_d = count_q + 64'd1;
    end
  end

  // State registers, cleared asynchronously by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tohost_q   <= '0;
      mismatch_q <= 1'b0;
      count_q    <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tohost_q   <= tohost_d;
      mismatch_q <= mismatch_d;
      count_q    <= count_d;
    end
  end

  assign tohost       = tohost_q;
  assign mismatch     = mismatch_q;
  assign commit_count = count_q;

endmodule

// File: tb/tb_cj.sv
// Self-checking bench for cj: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_cj;

  localparam int unsigned Depth = 8;
  localparam logic [63:0] Addr  = 64'h8000_1000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        dut_valid = 1'b0;
  logic [63:0] dut_pc = '0;
  logic [31:0] dut_inst = '0;
  logic        dut_wen = 1'b0;
  logic [4:0]  dut_rd = '0;
  logic [63:0] dut_wdata = '0;
  logic        ref_valid = 1'b0;
  logic        ref_ready;
  logic [63:0] ref_pc = '0;
  logic [31:0] ref_inst = '0;
  logic        ref_wen = 1'b0;
  logic [4:0]  ref_rd = '0;
  logic [63:0] ref_wdata = '0;
  logic        st_valid = 1'b0;
  logic [63:0] st_addr = '0;
  logic [63:0] st_data = '0;
  logic        set_valid = 1'b0;
  logic [63:0] set_value = '0;
  logic [63:0] tohost;
  logic        mismatch;
  logic [63:0] commit_count;

  int tests = 0;
  int fails = 0;

  cj #(
    .XLEN       (64),
    .DEPTH      (Depth),
    .TOHOST_ADDR(Addr)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .dut_valid   (dut_valid),
    .dut_pc      (dut_pc),
    .dut_inst    (dut_inst),
    .dut_wen     (dut_wen),
    .dut_rd      (dut_rd),
    .dut_wdata   (dut_wdata),
    .ref_valid   (ref_valid),
    .ref_ready   (ref_ready),
    .ref_pc      (ref_pc),
    .ref_inst    (ref_inst),
    .ref_wen     (ref_wen),
    .ref_rd      (ref_rd),
    .ref_wdata   (ref_wdata),
    .st_valid    (st_valid),
    .st_addr     (st_addr),
    .st_data     (st_data),
    .set_valid   (set_valid),
    .set_value   (set_value),
    .tohost      (tohost),
    .mismatch    (mismatch),
    .commit_count(commit_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] wdata;
  } rec_t;

  // Reference model state.
  rec_t        mq[$];
  logic [63:0] m_tohost = '0;
  logic        m_mis = 1'b0;
  logic [63:0] m_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(input logic [63:0] pc, input logic [31:0] inst, input logic wen,
                              input logic [4:0] rd, input logic [63:0] wdata);
    rec_t r;
    r.pc = pc; r.inst = inst; r.wen = wen; r.rd = rd; r.wdata = wdata;
    return r;
  endfunction

  // Model: error code for a commit against the oldest golden record.
  function automatic logic [63:0] code_for(input rec_t d);
    rec_t h;
    if (mq.size() == 0) return 64'h27;
    h = mq[0];
    if (d.pc != h.pc) return 64'h21;
    if (d.inst != h.inst) return 64'h23;
    if (d.wen != h.wen) return 64'h29;
    if (d.wen && d.rd != h.rd) return 64'h29;
    if (d.wen && d.rd != 0 && d.wdata != h.wdata) return 64'h25;
    return 64'h0;
  endfunction

  always @(negedge reset) begin
    mq.delete();
    m_tohost = '0;
    m_mis    = 1'b0;
    m_cnt    = '0;
  end

  always @(posedge clock) begin
    if (reset) begin
      automatic logic        is_done = m_tohost[0];
      automatic logic        can_push = (mq.size() < Depth);
      automatic logic [63:0] code = '0;
      automatic logic [63:0] next_th = m_tohost;
      if (dut_valid && !is_done) begin
        code = code_for(mk(dut_pc, dut_inst, dut_wen, dut_rd, dut_wdata));
        if (mq.size() != 0) void'(mq.pop_front());
        if (code == 0) m_cnt = m_cnt + 64'd1;
        else m_mis = 1'b1;
      end
      if (ref_valid && can_push) mq.push_back(mk(ref_pc, ref_inst, ref_wen, ref_rd, ref_wdata));
      if (set_valid) next_th = set_value;
      else if (code != 0) next_th = code;
      else if (st_valid && st_addr == Addr && st_data != 0 && !is_done) next_th = st_data;
      m_tohost = next_th;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (reset) begin
      chk("model_tohost", tohost, m_tohost);
      chk("model_mismatch", {63'd0, mismatch}, {63'd0, m_mis});
      chk("model_count", commit_count, m_cnt);
      chk("model_ref_ready", {63'd0, ref_ready}, {63'd0, mq.size() < Depth});
    end
  end

  task automatic push_rec(input rec_t r);
    ref_pc = r.pc; ref_inst = r.inst; ref_wen = r.wen; ref_rd = r.rd; ref_wdata = r.wdata;
    ref_valid = 1'b1;
    @(negedge clock);
    ref_valid = 1'b0;
  endtask

  task automatic commit_rec(input rec_t r);
    dut_pc = r.pc; dut_inst = r.inst; dut_wen = r.wen; dut_rd = r.rd; dut_wdata = r.wdata;
    dut_valid = 1'b1;
    @(negedge clock);
    dut_valid = 1'b0;
  endtask

  task automatic do_store(input logic [63:0] addr, input logic [63:0] data);
    st_addr = addr; st_data = data; st_valid = 1'b1;
    @(negedge clock);
    st_valid = 1'b0;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear with no clock edge.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b0;
    #1;
    chk({tag, "_rst_tohost"}, tohost, 64'h0);
    chk({tag, "_rst_mismatch"}, {63'd0, mismatch}, 64'h0);
    chk({tag, "_rst_count"}, commit_count, 64'h0);
    chk({tag, "_rst_ready"}, {63'd0, ref_ready}, 64'h1);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    rec_t r [Depth];
    rec_t bad;

    repeat (2) @(negedge clock);
    chk("init_tohost", tohost, 64'h0);
    chk("init_count", commit_count, 64'h0);
    chk("init_ready", {63'd0, ref_ready}, 64'h1);
    reset = 1'b1;

    // Three matching commits then a pass store.
    for (int i = 0; i < 3; i++) begin
      r[i] = mk(64'h8000_0000 + 64'(4 * i), 32'h0000_0013 + 32'(i), 1'b1, 5'(i + 1),
                64'h100 + 64'(i));
      push_rec(r[i]);
    end
    for (int i = 0; i < 3; i++) commit_rec(r[i]);
    chk("t1_count", commit_count, 64'd3);
    do_store(Addr, 64'h0);
    do_store(Addr + 64'd8, 64'h1);
    chk("t1_ignored_store", tohost, 64'h0);
    do_store(Addr, 64'h1);
    chk("t1_tohost", tohost, 64'h1);
    chk("t1_mismatch", {63'd0, mismatch}, 64'h0);
    commit_rec(r[0]);
    chk("t1_frozen_count", commit_count, 64'd3);

    // PC mismatch; a later pass store is ignored.
    do_reset("t2");
    push_rec(mk(64'h8000_0004, 32'h13, 1'b0, 5'd0, 64'h0));
    commit_rec(mk(64'h8000_0008, 32'h13, 1'b0, 5'd0, 64'h0));
    chk("t2_tohost", tohost, 64'h21);
    chk("t2_mismatch", {63'd0, mismatch}, 64'h1);
    do_store(Addr, 64'h1);
    chk("t2_store_ignored", tohost, 64'h21);

    // Write data mismatch.
    do_reset("t3");
    push_rec(mk(64'h8000_0000, 32'h33, 1'b1, 5'd5, 64'h10));
    commit_rec(mk(64'h8000_0000, 32'h33, 1'b1, 5'd5, 64'h11));
    chk("t3_tohost", tohost, 64'h25);

    // Same data mismatch to x0 is not an error.
    do_reset("t3b");
    push_rec(mk(64'h8000_0000, 32'h33, 1'b1, 5'd0, 64'h10));
    commit_rec(mk(64'h8000_0000, 32'h33, 1'b1, 5'd0, 64'h11));
    chk("t3b_tohost", tohost, 64'h0);
    chk("t3b_count", commit_count, 64'd1);

    // Instruction mismatch, then rd mismatch.
    do_reset("t3c");
    push_rec(mk(64'h8000_0000, 32'h33, 1'b1, 5'd5, 64'h10));
    commit_rec(mk(64'h8000_0000, 32'h37, 1'b1, 5'd6, 64'h11));
    chk("t3c_tohost", tohost, 64'h23);
    do_reset("t3d");
    push_rec(mk(64'h8000_0000, 32'h33, 1'b1, 5'd5, 64'h10));
    commit_rec(mk(64'h8000_0000, 32'h33, 1'b1, 5'd6, 64'h11));
    chk("t3d_tohost", tohost, 64'h29);

    // Commit with nothing buffered; a same-cycle push does not bypass.
    do_reset("t4");
    ref_pc = 64'h8000_0000; ref_inst = 32'h13; ref_wen = 1'b0; ref_rd = 5'd0; ref_wdata = '0;
    ref_valid = 1'b1;
    commit_rec(mk(64'h8000_0000, 32'h13, 1'b0, 5'd0, 64'h0));
    ref_valid = 1'b0;
    chk("t4_tohost", tohost, 64'h27);

    // Fill, drain one, then override alongside a mismatch, then reset.
    do_reset("t5");
    for (int i = 0; i < int'(Depth); i++) begin
      r[i] = mk(64'h1000 + 64'(4 * i), 32'h13, 1'b1, 5'd1, 64'(i));
      push_rec(r[i]);
    end
    chk("t5_full", {63'd0, ref_ready}, 64'h0);
    push_rec(mk(64'hdead, 32'h0, 1'b0, 5'd0, 64'h0));
    chk("t5_still_full", {63'd0, ref_ready}, 64'h0);
    commit_rec(r[0]);
    chk("t5_ready", {63'd0, ref_ready}, 64'h1);
    chk("t5_count", commit_count, 64'd1);
    bad = mk(64'hbad0, 32'h13, 1'b1, 5'd1, 64'h1);
    set_valid = 1'b1;
    set_value = 64'd5;
    commit_rec(bad);
    set_valid = 1'b0;
    chk("t6_tohost", tohost, 64'h5);
    push_rec(mk(64'h2000, 32'h13, 1'b0, 5'd0, 64'h0));
    push_rec(mk(64'h2004, 32'h13, 1'b0, 5'd0, 64'h0));
    chk("t6_refull", {63'd0, ref_ready}, 64'h0);
    do_reset("t6");

    repeat (2) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
